// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with per-lane byte enables, selectable
// read-during-write behaviour, optional output register and a post-reset zero-fill sweep.
module sp_ram_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 6,
    parameter int BYTE_WIDTH     = 8,
    parameter int WRITE_MODE     = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be,
    input  logic [ADDR_WIDTH-1:0]              addr,
    input  logic [DATA_WIDTH-1:0]              data,
    output logic [DATA_WIDTH-1:0]              q,
    output logic                               busy
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    generate
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
            $error("sp_ram_param: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (WRITE_MODE < 0 || WRITE_MODE > 2) begin : g_bad_mode
            $error("sp_ram_param: WRITE_MODE must be 0, 1 or 2");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   rd_q, rd_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [NB-1:0]           wr_lane;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   rdw_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (state_q == CLEAR) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
        end
    end

    // The sweep owns the single write port while it runs; user requests are dropped.
    always_comb begin
        wr_lane = '0;
        wr_addr = addr;
        wr_data = data;
        if (state_q == CLEAR) begin
            wr_lane = '1;
            wr_addr = cnt_q;
            wr_data = '0;
        end else if (we) begin
            wr_lane = be;
        end
    end

    assign old_word = mem[addr];

    generate
        if (WRITE_MODE == 1) begin : g_write_first
            logic [DATA_WIDTH-1:0] merged_word;
            always_comb begin
                merged_word = old_word;
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = data[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
            assign rdw_word = merged_word;
        end else if (WRITE_MODE == 2) begin : g_no_change
            assign rdw_word = rd_q;
        end else begin : g_read_first
            assign rdw_word = old_word;
        end
    endgenerate

    always_comb begin
        rd_d = '0;
        if (state_q == IDLE) begin
            rd_d = we ? rdw_word : old_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt_q   <= '0;
            busy_q  <= (CLEAR_ON_RESET != 0);
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
        end
    end

    // Array has no reset so that it maps onto block RAM with byte-write enables.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_lane[i]) begin
                mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] pipe_q, pipe_d;
            always_comb begin
                pipe_d = rd_q;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end
            assign q = pipe_q;
        end else begin : g_no_out_reg
            assign q = rd_q;
        end
    endgenerate

    assign busy = busy_q;

endmodule

// File: tb/tb_sp_ram_param.sv
// Bench for sp_ram_param: three differently parametrised instances share one stimulus
// stream and are checked every cycle against a word-level array model.
module tb_sp_ram_param;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] data;

    logic [7:0]  q_a;
    logic [31:0] q_b;
    logic [15:0] q_c;
    logic        busy_a, busy_b, busy_c;

    int n_checks;
    int n_errors;

    // a: 8-bit read-first, b: 32-bit write-first registered, c: 16-bit no-change without clear
    sp_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .BYTE_WIDTH(8),
                   .WRITE_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst_n(rst_n), .we(we), .be(be[0:0]), .addr(addr),
        .data(data[7:0]), .q(q_a), .busy(busy_a));

    sp_ram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8),
                   .WRITE_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst_n(rst_n), .we(we), .be(be), .addr(addr),
        .data(data), .q(q_b), .busy(busy_b));

    sp_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .BYTE_WIDTH(8),
                   .WRITE_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(0)) u_c (
        .clk(clk), .rst_n(rst_n), .we(we), .be(be[1:0]), .addr(addr),
        .data(data[15:0]), .q(q_c), .busy(busy_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: value visible on q after the edges seen so far, plus known-bit masks
    logic [31:0] m_mem   [3][64] = '{default: '0};
    logic [31:0] m_known [3][64] = '{default: '0};
    logic [31:0] m_rd    [3];
    logic [31:0] m_rd_k  [3];
    logic [31:0] m_pipe  [3];
    logic [31:0] m_pipe_k[3];
    int          m_left  [3];

    function automatic logic [31:0] dmask_of(input int k);
        case (k)
            0:       return 32'h0000_00FF;
            1:       return 32'hFFFF_FFFF;
            default: return 32'h0000_FFFF;
        endcase
    endfunction

    function automatic int nb_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 2;
    endfunction

    function automatic int mode_of(input int k);
        return k;
    endfunction

    function automatic bit outreg_of(input int k);
        return (k == 1);
    endfunction

    function automatic bit clr_of(input int k);
        return (k != 2);
    endfunction

    function automatic logic [31:0] lane_mask(input int k, input logic [3:0] b);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < nb_of(k); i++) begin
            if (b[i]) m = m | (32'h0000_00FF << (8 * i));
        end
        return m;
    endfunction

    function automatic logic [31:0] dut_q(input int k);
        case (k)
            0:       return {24'h0, q_a};
            1:       return q_b;
            default: return {16'h0, q_c};
        endcase
    endfunction

    function automatic logic dut_busy(input int k);
        return (k == 0) ? busy_a : (k == 1) ? busy_b : busy_c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            if (clr_of(k)) begin
                for (int a = 0; a < 64; a++) begin
                    m_mem[k][a]   = '0;
                    m_known[k][a] = dmask_of(k);
                end
            end
            m_rd[k]     = '0;
            m_rd_k[k]   = dmask_of(k);
            m_pipe[k]   = '0;
            m_pipe_k[k] = dmask_of(k);
            m_left[k]   = clr_of(k) ? 64 : 0;
        end
    endtask

    // Advance the model by one rising edge with the given request applied
    task automatic model_advance(input logic w, input logic [3:0] b, input logic [5:0] a,
                                 input logic [31:0] d);
        logic [31:0] dm, lm, old, oldk, merged, mk, nr, nrk;
        for (int k = 0; k < 3; k++) begin
            dm = dmask_of(k);
            m_pipe[k]   = m_rd[k];
            m_pipe_k[k] = m_rd_k[k];
            if (m_left[k] > 0) begin
                m_left[k] = m_left[k] - 1;
                m_rd[k]   = '0;
                m_rd_k[k] = dm;
            end else begin
                lm     = w ? lane_mask(k, b) : 32'h0;
                old    = m_mem[k][a];
                oldk   = m_known[k][a];
                merged = ((old & ~lm) | (d & lm)) & dm;
                mk     = (oldk | lm) & dm;
                nr     = old;
                nrk    = oldk;
                if (w) begin
                    if (mode_of(k) == 1) begin
                        nr  = merged;
                        nrk = mk;
                    end else if (mode_of(k) == 2) begin
                        nr  = m_rd[k];
                        nrk = m_rd_k[k];
                    end
                    m_mem[k][a]   = merged;
                    m_known[k][a] = mk;
                end
                m_rd[k]   = nr;
                m_rd_k[k] = nrk;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks = n_checks + 1;
        if (actual !== expected) begin
            n_errors = n_errors + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_q, exp_k;
        for (int k = 0; k < 3; k++) begin
            exp_q = outreg_of(k) ? m_pipe[k]   : m_rd[k];
            exp_k = outreg_of(k) ? m_pipe_k[k] : m_rd_k[k];
            checkOutput($sformatf("model_q[%0d]", k), dut_q(k) & exp_k, exp_q & exp_k);
            checkOutput($sformatf("model_busy[%0d]", k), {31'h0, dut_busy(k)},
                        {31'h0, (m_left[k] > 0)});
        end
    endtask

    // Compare what the previous edge produced, then present the next request
    task automatic applyStimulus(input logic w, input logic [3:0] b, input logic [5:0] a,
                                 input logic [31:0] d);
        @(negedge clk);
        compare_all();
        we   = w;
        be   = b;
        addr = a;
        data = d;
        if (rst_n) model_advance(w, b, a, d);
    endtask

    task automatic sample_after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_edges;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        we    = 1'b0;
        be    = 4'h0;
        addr  = 6'h0;
        data  = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        release_reset();

        // No-clear instance is usable right away while the others sweep
        applyStimulus(1'b1, 4'hF, 6'd63, 32'h0000_BEEF);
        applyStimulus(1'b0, 4'h0, 6'd63, 32'h0);
        sample_after_edge();
        checkOutput("c_write_read_63", {16'h0, q_c}, 32'h0000_BEEF);
        checkOutput("c_busy_low", {31'h0, busy_c}, 32'h0);
        for (int i = 2; i < 63; i++) applyStimulus(1'b0, 4'h0, 6'd0, 32'h0);
        sample_after_edge();
        checkOutput("a_busy_edge63", {31'h0, busy_a}, 32'h1);
        applyStimulus(1'b0, 4'h0, 6'd0, 32'h0);
        sample_after_edge();
        checkOutput("a_busy_edge64", {31'h0, busy_a}, 32'h0);
        checkOutput("b_busy_edge64", {31'h0, busy_b}, 32'h0);
        applyStimulus(1'b0, 4'h0, 6'd63, 32'h0);
        sample_after_edge();
        checkOutput("a_busy_write_dropped", {24'h0, q_a}, 32'h0);

        $display("[TB] read back cleared array");
        for (int a = 0; a < 64; a++) applyStimulus(1'b0, 4'h0, 6'(a), 32'h0);

        $display("[TB] random fill and readback");
        for (int a = 0; a < 64; a++) applyStimulus(1'b1, 4'hF, 6'(a), $urandom);
        for (int a = 0; a < 64; a++) applyStimulus(1'b0, 4'h0, 6'(a), 32'h0);

        $display("[TB] byte-lane merge");
        applyStimulus(1'b1, 4'hF, 6'd5, 32'hAABB_CCDD);
        applyStimulus(1'b1, 4'b0101, 6'd5, 32'h1122_3344);
        applyStimulus(1'b0, 4'h0, 6'd5, 32'h0);
        sample_after_edge();
        checkOutput("a_lane_merge", {24'h0, q_a}, 32'h0000_0044);
        checkOutput("c_lane_merge", {16'h0, q_c}, 32'h0000_CC44);
        applyStimulus(1'b0, 4'h0, 6'd5, 32'h0);
        sample_after_edge();
        checkOutput("b_lane_merge", q_b, 32'hAA22_CC44);

        $display("[TB] read-during-write modes");
        applyStimulus(1'b1, 4'hF, 6'd3, 32'h0000_005A);
        applyStimulus(1'b1, 4'hF, 6'd3, 32'h0000_00C3);
        sample_after_edge();
        checkOutput("a_read_first", {24'h0, q_a}, 32'h0000_005A);
        applyStimulus(1'b0, 4'h0, 6'd3, 32'h0);
        sample_after_edge();
        checkOutput("b_write_first_late", q_b, 32'h0000_00C3);
        checkOutput("a_read_after_write", {24'h0, q_a}, 32'h0000_00C3);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                          6'($urandom_range(63, 0)), $urandom);
        end

        $display("[TB] reset during clear sweep");
        assert_reset();
        release_reset();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 4'hF, 6'd9, $urandom);
        assert_reset();
        release_reset();
        n_edges = 0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b1, 4'hF, 6'd9, $urandom);
            sample_after_edge();
            n_edges = n_edges + 1;
            if (!busy_a) break;
        end
        checkOutput("a_busy_after_abort", 32'(n_edges), 32'd64);
        applyStimulus(1'b0, 4'h0, 6'd9, 32'h0);
        sample_after_edge();
        checkOutput("a_busy_writes_dropped", {24'h0, q_a}, 32'h0);
        applyStimulus(1'b0, 4'h0, 6'd9, 32'h0);
        applyStimulus(1'b0, 4'h0, 6'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
